forest_vote_accum: RTL



---
 rtl/forest_vote_accum.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/forest_vote_accum.sv
// forest_vote_accum
// Collects one sample of 1-bit tree votes, tallies them per class one tree
// per cycle, then scans the tallies for the winning class (lowest index wins
// on equal counts) and offers the result on a valid/ready handshake.
module forest_vote_accum #(
  parameter int N_CLASSES = 5,
  parameter int N_TREES   = 3,
  localparam int CW = $clog2(N_TREES + 1),
  localparam int IW = $clog2(N_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_CLASSES*N_TREES-1:0] votes,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IW-1:0]                out_class,
  output logic [CW-1:0]                out_count,
  output logic                         out_tie
);

  // Tree index needs at least one bit even for a single tree.
  localparam int TW = (N_TREES > 1) ? $clog2(N_TREES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] ARGMAX = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  logic [1:0]                   state_reg;
  logic [N_CLASSES*N_TREES-1:0] votes_reg;
  logic [TW-1:0]                t_reg;
  logic [IW-1:0]                k_reg;
  logic [CW-1:0]                cnt_reg [N_CLASSES];
  logic [CW-1:0]                best_reg, best_next;
  logic [IW-1:0]                best_idx_reg, best_idx_next;
  logic                         tie_reg, tie_next;
  logic [CW-1:0]                cnt_k;
  logic [N_CLASSES-1:0]         vote_bit;
  logic                         accept;
  logic                         t_last;
  logic                         k_last;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == OUT);
  assign accept    = in_valid & in_ready;
  assign t_last    = (t_reg == TW'(N_TREES - 1));
  assign k_last    = (k_reg == IW'(N_CLASSES - 1));

  // Pick out the vote of tree t for every class from the captured sample.
  for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_vote
    logic [N_TREES-1:0] class_votes;
    assign class_votes  = votes_reg[gi*N_TREES +: N_TREES];
    assign vote_bit[gi] = class_votes[t_reg];
  end

  // One argmax step: fold cnt[k] into the running best; only a strictly
  // greater count displaces the current leader, so lower indices win ties.
  always_comb begin
    cnt_k         = cnt_reg[k_reg];
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    tie_next      = tie_reg;
    if (k_reg == '0) begin
      best_next     = cnt_k;
      best_idx_next = '0;
      tie_next      = 1'b0;
    end else if (cnt_k > best_reg) begin
      best_next     = cnt_k;
      best_idx_next = k_reg;
      tie_next      = 1'b0;
    end else if (cnt_k == best_reg) begin
      tie_next      = 1'b1;
    end
  end

  // Per-class vote counters: cleared on accept, one tree added per COUNT cycle.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CLASSES; c++) begin
      if (rst || accept) begin
        cnt_reg[c] <= '0;
      end else if (state_reg == COUNT) begin
        cnt_reg[c] <= cnt_reg[c] + CW'(vote_bit[c]);
      end
    end
  end

  // Control FSM with sample capture, argmax registers and the result holding stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      votes_reg    <= '0;
      t_reg        <= '0;
      k_reg        <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
      tie_reg      <= 1'b0;
      out_class    <= '0;
      out_count    <= '0;
      out_tie      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            votes_reg <= votes;
            t_reg     <= '0;
            state_reg <= COUNT;
          end
        end
        COUNT: begin
          if (t_last) begin
            t_reg     <= '0;
            k_reg     <= '0;
            state_reg <= ARGMAX;
          end else begin
            t_reg <= t_reg + 1'b1;
          end
        end
        ARGMAX: begin
          best_reg     <= best_next;
          best_idx_reg <= best_idx_next;
          tie_reg      <= tie_next;
          if (k_last) begin
            k_reg     <= '0;
            out_class <= best_idx_next;
            out_count <= best_next;
            out_tie   <= tie_next;
            state_reg <= OUT;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
